// File: rtl/sgd_dispatch_mc.sv
// Response dispatcher: routes tagged read-response beats to the A channel FIFOs,
// or unpacks them into B slices with back-pressure. Also exports status counters.
module sgd_dispatch_mc #(
    parameter int              DATA_W      = 512,
    parameter int              NUM_BANKS   = 8,
    parameter int              B_LANE_W    = 32,
    parameter int              NUM_A_CH    = 2,
    parameter int              TAG_W       = 8,
    parameter logic [TAG_W-1:0] A_TAG_BASE = 8'h00,
    parameter logic [TAG_W-1:0] B_TAG      = 8'h80,
    parameter bit              B_LSB_FIRST = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            started,
    input  logic [TAG_W-1:0]                rx_tag,
    input  logic [DATA_W-1:0]               rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [DATA_W-1:0]               a_data,
    output logic [NUM_A_CH-1:0]             a_wr_en,
    input  logic [NUM_A_CH-1:0]             a_almost_full,
    output logic [B_LANE_W*NUM_BANKS-1:0]   b_data,
    output logic                            b_wr_en,
    input  logic                            b_almost_full,
    output logic [31:0]                     cnt_a_beats,
    output logic [31:0]                     cnt_b_lines,
    output logic [31:0]                     cnt_stall,
    output logic [31:0]                     cnt_bad_tag,
    output logic                            err_bad_tag
);

    localparam int B_SLICE_W = B_LANE_W * NUM_BANKS;
    localparam int NSLICE    = DATA_W / B_SLICE_W;
    localparam int IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {
        B_IDLE,
        B_DRAIN
    } b_state_t;

    b_state_t                r_b_state;
    b_state_t                w_b_state_nxt;

    logic                    r_started;
    logic                    r_rx_ready;
    logic [DATA_W-1:0]       r_a_data;
    logic [NUM_A_CH-1:0]     r_a_wr_en;
    logic [DATA_W-1:0]       r_b_buf;
    logic [IDX_W-1:0]        r_slice_idx;
    logic                    r_b_cnt;
    logic [B_SLICE_W-1:0]    r_b_data;
    logic                    r_b_wr_en;
    logic [31:0]             r_cnt_a_beats;
    logic [31:0]             r_cnt_b_lines;
    logic [31:0]             r_cnt_stall;
    logic [31:0]             r_cnt_bad_tag;
    logic                    r_err_bad_tag;

    logic                    w_acc;
    logic [TAG_W-1:0]        w_a_off;
    logic                    w_is_a;
    logic                    w_is_b;
    logic                    w_acc_a;
    logic                    w_acc_b;
    logic                    w_acc_bad;
    logic [NUM_A_CH-1:0]     w_a_onehot;
    logic                    w_b_load;
    logic                    w_b_issue;
    logic                    w_b_last;
    logic [IDX_W-1:0]        w_sel;
    logic [B_SLICE_W-1:0]    w_slice;
    logic                    w_rx_ready_nxt;

    // Tag decode; the offset wraps in TAG_W bits so a single compare covers the A range.
    assign w_acc     = rx_valid & r_rx_ready;
    assign w_a_off   = rx_tag - A_TAG_BASE;
    assign w_is_a    = (w_a_off < TAG_W'(NUM_A_CH));
    assign w_is_b    = (rx_tag == B_TAG) & ~w_is_a;
    assign w_acc_a   = w_acc & w_is_a;
    assign w_acc_b   = w_acc & w_is_b;
    assign w_acc_bad = w_acc & ~w_is_a & ~w_is_b;

    always_comb begin
        w_a_onehot = '0;
        for (int unsigned i = 0; i < NUM_A_CH; i++) begin
            if (w_acc_a && (w_a_off == TAG_W'(i))) begin
                w_a_onehot[i] = 1'b1;
            end
        end
    end

    // Ready stays low while a B line is buffered, so one line of storage is enough.
    assign w_rx_ready_nxt = r_started & ~|a_almost_full & ~b_almost_full
                          & ~r_b_cnt & ~w_acc_b;

    assign w_b_last = (r_slice_idx == IDX_W'(NSLICE - 1));
    assign w_sel    = B_LSB_FIRST ? r_slice_idx : (IDX_W'(NSLICE - 1) - r_slice_idx);

    always_comb begin
        w_slice = '0;
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (w_sel == IDX_W'(s)) begin
                w_slice = r_b_buf[s*B_SLICE_W +: B_SLICE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b_state <= B_IDLE;
        end else begin
            r_b_state <= w_b_state_nxt;
        end
    end

    always_comb begin
        w_b_state_nxt = r_b_state;
        w_b_load      = 1'b0;
        w_b_issue     = 1'b0;
        case (r_b_state)
            B_IDLE: begin
                if (w_acc_b) begin
                    w_b_load      = 1'b1;
                    w_b_state_nxt = B_DRAIN;
                end
            end
            B_DRAIN: begin
                if (!b_almost_full) begin
                    w_b_issue = 1'b1;
                    if (w_b_last) begin
                        w_b_state_nxt = B_IDLE;
                    end
                end
            end
            default: w_b_state_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_started     <= 1'b0;
            r_rx_ready    <= 1'b0;
            r_a_data      <= '0;
            r_a_wr_en     <= '0;
            r_b_buf       <= '0;
            r_slice_idx   <= '0;
            r_b_cnt       <= 1'b0;
            r_b_data      <= '0;
            r_b_wr_en     <= 1'b0;
            r_cnt_a_beats <= '0;
            r_cnt_b_lines <= '0;
            r_cnt_stall   <= '0;
            r_cnt_bad_tag <= '0;
            r_err_bad_tag <= 1'b0;
        end else begin
            r_started  <= r_started | started;
            r_rx_ready <= w_rx_ready_nxt;

            r_a_wr_en <= w_a_onehot;
            if (w_acc_a) begin
                r_a_data <= rx_data;
            end

            if (w_b_load) begin
                r_b_buf     <= rx_data;
                r_slice_idx <= '0;
                r_b_cnt     <= 1'b1;
            end

            r_b_wr_en <= w_b_issue;
            if (w_b_issue) begin
                r_b_data    <= w_slice;
                r_slice_idx <= r_slice_idx + IDX_W'(1);
                if (w_b_last) begin
                    r_b_cnt <= 1'b0;
                end
            end

            if (w_acc_a) begin
                r_cnt_a_beats <= r_cnt_a_beats + 32'd1;
            end
            if (w_acc_b) begin
                r_cnt_b_lines <= r_cnt_b_lines + 32'd1;
            end
            if (r_started && !r_rx_ready) begin
                r_cnt_stall <= r_cnt_stall + 32'd1;
            end
            if (w_acc_bad) begin
                r_cnt_bad_tag <= r_cnt_bad_tag + 32'd1;
                r_err_bad_tag <= 1'b1;
            end
        end
    end

    assign rx_ready    = r_rx_ready;
    assign a_data      = r_a_data;
    assign a_wr_en     = r_a_wr_en;
    assign b_data      = r_b_data;
    assign b_wr_en     = r_b_wr_en;
    assign cnt_a_beats = r_cnt_a_beats;
    assign cnt_b_lines = r_cnt_b_lines;
    assign cnt_stall   = r_cnt_stall;
    assign cnt_bad_tag = r_cnt_bad_tag;
    assign err_bad_tag = r_err_bad_tag;

endmodule

// File: tb/tb_sgd_dispatch_mc.sv
// Bench for sgd_dispatch_mc: directed and random traffic checked every cycle
// against a transaction-level model of ready, routing, B unpacking and counters.
module tb_sgd_dispatch_mc;

    localparam int NA = 2;
    localparam int SW = 256;
    localparam int NS = 2;

    logic         clk;
    logic         rst_n;
    logic         started;
    logic [7:0]   rx_tag;
    logic [511:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [511:0] a_data;
    logic [1:0]   a_wr_en;
    logic [1:0]   a_almost_full;
    logic [255:0] b_data;
    logic         b_wr_en;
    logic         b_almost_full;
    logic [31:0]  cnt_a_beats;
    logic [31:0]  cnt_b_lines;
    logic [31:0]  cnt_stall;
    logic [31:0]  cnt_bad_tag;
    logic         err_bad_tag;

    sgd_dispatch_mc #(
        .DATA_W(512), .NUM_BANKS(8), .B_LANE_W(32), .NUM_A_CH(NA), .TAG_W(8),
        .A_TAG_BASE(8'h00), .B_TAG(8'h80), .B_LSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .started(started),
        .rx_tag(rx_tag), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .a_data(a_data), .a_wr_en(a_wr_en), .a_almost_full(a_almost_full),
        .b_data(b_data), .b_wr_en(b_wr_en), .b_almost_full(b_almost_full),
        .cnt_a_beats(cnt_a_beats), .cnt_b_lines(cnt_b_lines), .cnt_stall(cnt_stall),
        .cnt_bad_tag(cnt_bad_tag), .err_bad_tag(err_bad_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           n_tests = 0;
    int           n_fail  = 0;

    // Reference model state (expected DUT outputs after the next edge)
    bit           m_started, m_ready, m_b_wr, m_err, last_acc;
    logic [1:0]   m_a_wr;
    logic [511:0] m_a_data, m_line;
    logic [255:0] m_b_data;
    int           m_left;
    logic [31:0]  m_ca, m_cb, m_cs, m_cbad;

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_started = 0; m_ready = 0; m_b_wr = 0; m_err = 0; last_acc = 0;
        m_a_wr = '0; m_a_data = '0; m_b_data = '0; m_line = '0; m_left = 0;
        m_ca = '0; m_cb = '0; m_cs = '0; m_cbad = '0;
    endtask

    // One clock: advance the model from the inputs currently driven, then compare.
    task automatic step();
        bit acc, is_a, is_b, n_ready;
        if (!rst_n) begin
            model_reset();
        end else begin
            acc     = rx_valid && m_ready;
            is_a    = (rx_tag < NA);
            is_b    = (rx_tag == 8'h80);
            n_ready = m_started && (a_almost_full == 2'b00) && !b_almost_full
                      && (m_left == 0) && !(acc && is_b);
            if (acc && is_a) begin
                m_a_wr   = 2'(1 << rx_tag);
                m_a_data = rx_data;
                m_ca++;
            end else begin
                m_a_wr = '0;
            end
            if (m_left > 0 && !b_almost_full) begin
                m_b_data = 256'(m_line >> ((NS - m_left) * SW));
                m_b_wr   = 1;
                m_left--;
            end else begin
                m_b_wr = 0;
            end
            if (acc && is_b) begin
                m_line = rx_data;
                m_left = NS;
                m_cb++;
            end
            if (acc && !is_a && !is_b) begin
                m_cbad++;
                m_err = 1;
            end
            if (m_started && !m_ready) m_cs++;
            m_started = m_started || started;
            m_ready   = n_ready;
            last_acc  = acc;
        end
        @(posedge clk);
        #1;
        chk("rx_ready", rx_ready, m_ready);
        chk("a_wr_en", a_wr_en, m_a_wr);
        chk("a_data", a_data, m_a_data);
        chk("b_wr_en", b_wr_en, m_b_wr);
        chk("b_data", b_data, m_b_data);
        chk("cnt_a_beats", cnt_a_beats, m_ca);
        chk("cnt_b_lines", cnt_b_lines, m_cb);
        chk("cnt_stall", cnt_stall, m_cs);
        chk("cnt_bad_tag", cnt_bad_tag, m_cbad);
        chk("err_bad_tag", err_bad_tag, m_err);
    endtask

    // Holds rx_valid until the beat is accepted; returns in the cycle after acceptance.
    task automatic send_beat(input logic [7:0] tag, input logic [511:0] data);
        bit accepted = 0;
        rx_tag   = tag;
        rx_data  = data;
        rx_valid = 1'b1;
        for (int i = 0; i < 64 && !accepted; i++) begin
            step();
            accepted = last_acc;
        end
        chk("accept_within_bound", accepted, 1'b1);
    endtask

    initial begin
        logic [511:0] d [6];
        logic [511:0] bline;

        bline = {256'hB1, 256'hB0};
        rst_n = 1'b0; started = 1'b0; rx_valid = 1'b0; rx_tag = '0; rx_data = '0;
        a_almost_full = '0; b_almost_full = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_ready", rx_ready, 1'b0);
        chk("rst_cnt_a", cnt_a_beats, 32'd0);

        // Not yet started: valid traffic is ignored
        rst_n = 1'b1;
        rx_valid = 1'b1;
        repeat (3) begin
            step();
            chk("prestart_a_wr", a_wr_en, 2'b00);
        end
        rx_valid = 1'b0;
        started = 1'b1;
        step();
        started = 1'b0;
        step();
        chk("ready_after_start", rx_ready, 1'b1);

        // A stream: 4 beats to channel 0, 2 to channel 1, valid held
        for (int k = 0; k < 6; k++) begin
            d[k] = rnd512();
            send_beat((k < 4) ? 8'h00 : 8'h01, d[k]);
            chk("stream_wr", a_wr_en, (k < 4) ? 2'b01 : 2'b10);
            chk("stream_data", a_data, d[k]);
        end
        rx_valid = 1'b0;
        step();
        chk("cnt_a_six", cnt_a_beats, 32'd6);

        // B line without back-pressure
        send_beat(8'h80, bline);
        rx_valid = 1'b0;
        chk("b_ready_t1", rx_ready, 1'b0);
        step();
        chk("b_wr_t2", b_wr_en, 1'b1);
        chk("b_data_t2", b_data, 256'hB0);
        chk("b_ready_t2", rx_ready, 1'b0);
        step();
        chk("b_wr_t3", b_wr_en, 1'b1);
        chk("b_data_t3", b_data, 256'hB1);
        chk("b_ready_t3", rx_ready, 1'b0);
        step();
        chk("b_ready_t4", rx_ready, 1'b1);
        chk("cnt_b_one", cnt_b_lines, 32'd1);

        // B line with b_almost_full during t+1..t+5
        send_beat(8'h80, bline);
        rx_valid = 1'b0;
        b_almost_full = 1'b1;
        repeat (5) begin
            step();
            chk("bstall_no_wr", b_wr_en, 1'b0);
        end
        b_almost_full = 1'b0;
        step();
        chk("bstall_t7_wr", b_wr_en, 1'b1);
        chk("bstall_t7_data", b_data, 256'hB0);
        step();
        chk("bstall_t8_wr", b_wr_en, 1'b1);
        chk("bstall_t8_data", b_data, 256'hB1);
        repeat (2) step();
        chk("cnt_b_two", cnt_b_lines, 32'd2);

        // a_almost_full[1] asserted while streaming to channel 0
        rx_tag = 8'h00; rx_data = rnd512(); rx_valid = 1'b1;
        repeat (3) begin
            step();
            if (last_acc) rx_data = rnd512();
        end
        a_almost_full = 2'b10;
        step();
        if (last_acc) rx_data = rnd512();
        chk("aaf_ready_drop", rx_ready, 1'b0);
        repeat (3) begin
            step();
            chk("aaf_held_low", rx_ready, 1'b0);
        end
        a_almost_full = 2'b00;
        step();
        chk("aaf_ready_back", rx_ready, 1'b1);
        step();
        rx_valid = 1'b0;
        step();

        // Unmapped tag
        send_beat(8'h42, rnd512());
        rx_valid = 1'b0;
        chk("bad_no_a", a_wr_en, 2'b00);
        chk("bad_no_b", b_wr_en, 1'b0);
        chk("bad_cnt", cnt_bad_tag, 32'd1);
        chk("bad_err", err_bad_tag, 1'b1);
        send_beat(8'h01, rnd512());
        rx_valid = 1'b0;
        step();
        chk("bad_err_sticky", err_bad_tag, 1'b1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rx_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: rx_tag = 8'h00;
                1: rx_tag = 8'h01;
                2: rx_tag = 8'h80;
                3: rx_tag = 8'h80;
                default: rx_tag = 8'($urandom);
            endcase
            rx_data = rnd512();
            a_almost_full = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            b_almost_full = ($urandom_range(0, 5) == 0);
            step();
        end
        rx_valid = 1'b0; a_almost_full = '0; b_almost_full = 1'b0;
        repeat (4) step();

        // Reset in cycle t+2 of a B drain
        send_beat(8'h80, rnd512());
        rx_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_ready", rx_ready, 1'b0);
        chk("mrst_b_wr", b_wr_en, 1'b0);
        chk("mrst_b_data", b_data, 256'h0);
        chk("mrst_cnt_b", cnt_b_lines, 32'd0);
        chk("mrst_cnt_stall", cnt_stall, 32'd0);
        chk("mrst_err", err_bad_tag, 1'b0);
        rst_n = 1'b1;
        repeat (2) begin
            step();
            chk("mrst_not_started", rx_ready, 1'b0);
        end
        started = 1'b1;
        step();
        started = 1'b0;
        step();
        bline = {256'hC1, 256'hC0};
        send_beat(8'h80, bline);
        rx_valid = 1'b0;
        step();
        chk("restart_b0", b_data, 256'hC0);
        step();
        chk("restart_b1", b_data, 256'hC1);
        repeat (2) step();
        chk("restart_cnt_b", cnt_b_lines, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
